// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: reset vector, exit syscall
// code, sequencer state encoding and next-PC source selection.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] SYSCALL_EXIT     = 32'd10;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } seq_state_e;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_BR,
        NPC_J,
        NPC_JR
    } npc_sel_e;

endpackage

// File: rtl/branch_cond.sv
// Conditional-branch resolution for the MIPS branch family; purely combinational.
// All comparisons treat rs/rt as signed 32-bit values.
module branch_cond (
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        beq,
    input  logic        bne,
    input  logic        blez,
    input  logic        bgtz,
    input  logic        bz,
    input  logic        bz_ge,
    output logic        taken
);

    logic rsEqRt;
    logic rsNeg;
    logic rsZero;

    // Sign and zero tests replace full signed comparators against zero.
    assign rsEqRt = (rs == rt);
    assign rsNeg  = rs[31];
    assign rsZero = (rs == 32'd0);

    assign taken = (beq  &  rsEqRt)
                 | (bne  & ~rsEqRt)
                 | (blez & (rsNeg | rsZero))
                 | (bgtz & ~rsNeg & ~rsZero)
                 | (bz   & (bz_ge ? ~rsNeg : rsNeg));

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC, next-PC selection, exit-syscall halt FSM and performance
// counters for the single-cycle MIPS core.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] EXIT_CODE = SYSCALL_EXIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beq,
    input  logic             bne,
    input  logic             blez,
    input  logic             bgtz,
    input  logic             bz,
    input  logic             bz_ge,
    input  logic             jmp,
    input  logic             jr,
    input  logic             syscall,
    input  logic [15:0]      imm16,
    input  logic [25:0]      target26,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic [31:0]      v0_data,
    input  logic             go,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             halted,
    output logic             branch_taken,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] jump_cnt,
    output logic [CNT_W-1:0] branch_cnt
);

    seq_state_e       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
    logic [CNT_W-1:0] jumpCnt_q, jumpCnt_d;
    logic [CNT_W-1:0] branchCnt_q, branchCnt_d;
    npc_sel_e         npcSel;
    logic [31:0]      npcTarget;
    logic [31:0]      branchOffset;

    branch_cond u_branch_cond (
        .rs    (rs_data),
        .rt    (rt_data),
        .beq   (beq),
        .bne   (bne),
        .blez  (blez),
        .bgtz  (bgtz),
        .bz    (bz),
        .bz_ge (bz_ge),
        .taken (branch_taken)
    );

    assign pc_plus4     = pc_q + 32'd4;
    assign branchOffset = {{14{imm16[15]}}, imm16, 2'b00};

    // JR outranks J, which outranks a taken branch, so malformed decodes stay deterministic.
    always_comb begin
        npcSel = NPC_SEQ;
        if (jr) begin
            npcSel = NPC_JR;
        end else if (jmp) begin
            npcSel = NPC_J;
        end else if (branch_taken) begin
            npcSel = NPC_BR;
        end
    end

    always_comb begin
        npcTarget = pc_plus4;
        unique case (npcSel)
            NPC_JR:  npcTarget = {rs_data[31:2], 2'b00};
            NPC_J:   npcTarget = {pc_plus4[31:28], target26, 2'b00};
            NPC_BR:  npcTarget = pc_plus4 + branchOffset;
            default: npcTarget = pc_plus4;
        endcase
    end

    // The halting syscall still counts as a RUN cycle; HALT freezes everything until go.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cycleCnt_d  = cycleCnt_q;
        jumpCnt_d   = jumpCnt_q;
        branchCnt_d = branchCnt_q;
        unique case (state_q)
            ST_RUN: begin
                cycleCnt_d  = cycleCnt_q + CNT_W'(1);
                jumpCnt_d   = jumpCnt_q + CNT_W'(jmp);
                branchCnt_d = branchCnt_q + CNT_W'(branch_taken);
                if (syscall && (v0_data == EXIT_CODE)) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d = npcTarget;
                end
            end
            ST_HALT: begin
                if (go) begin
                    state_d = ST_RUN;
                    pc_d    = pc_plus4;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            cycleCnt_q  <= '0;
            jumpCnt_q   <= '0;
            branchCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cycleCnt_q  <= cycleCnt_d;
            jumpCnt_q   <= jumpCnt_d;
            branchCnt_q <= branchCnt_d;
        end
    end

    assign pc         = pc_q;
    assign halted     = (state_q == ST_HALT);
    assign cycle_cnt  = cycleCnt_q;
    assign jump_cnt   = jumpCnt_q;
    assign branch_cnt = branchCnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequencing, branches, jumps,
// PC wrap, exit-syscall halt/resume and asynchronous reset during HALT.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        beq, bne, blez, bgtz, bz, bz_ge, jmp, jr, syscall, go;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] rs_data, rt_data, v0_data;
    logic [31:0] pc, pc_plus4;
    logic        halted, branch_taken;
    logic [31:0] cycle_cnt, jump_cnt, branch_cnt;

    int checkCount = 0;
    int failCount  = 0;
    int expCycle   = 0;
    int expJump    = 0;
    int expBranch  = 0;

    pc_sequencer #(
        .RESET_PC  (32'h0000_0000),
        .CNT_W     (32),
        .EXIT_CODE (32'd10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .beq          (beq),
        .bne          (bne),
        .blez         (blez),
        .bgtz         (bgtz),
        .bz           (bz),
        .bz_ge        (bz_ge),
        .jmp          (jmp),
        .jr           (jr),
        .syscall      (syscall),
        .imm16        (imm16),
        .target26     (target26),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .v0_data      (v0_data),
        .go           (go),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .halted       (halted),
        .branch_taken (branch_taken),
        .cycle_cnt    (cycle_cnt),
        .jump_cnt     (jump_cnt),
        .branch_cnt   (branch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, ".cycle"},  cycle_cnt,  32'(expCycle));
        checkOutput({tag, ".jump"},   jump_cnt,   32'(expJump));
        checkOutput({tag, ".branch"}, branch_cnt, 32'(expBranch));
    endtask

    task automatic clearStrobes();
        beq = 0; bne = 0; blez = 0; bgtz = 0; bz = 0; bz_ge = 0;
        jmp = 0; jr = 0; syscall = 0; go = 0;
        imm16 = 16'h0; target26 = 26'h0;
        rs_data = 32'h0; rt_data = 32'h0; v0_data = 32'h0;
    endtask

    // Inputs are already driven; advance one rising edge and sample 1 ns after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic jumpTo(input logic [31:0] addr);
        clearStrobes();
        jr = 1; jmp = 1; rs_data = addr;
        applyStimulus();
        expCycle++; expJump++;
        clearStrobes();
    endtask

    initial begin
        clearStrobes();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.pc", pc, 32'h0);
        checkOutput("reset.halted", 32'(halted), 32'h0);
        checkCounters("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(); checkOutput("idle.pc1", pc, 32'h4);
        applyStimulus(); checkOutput("idle.pc2", pc, 32'h8);
        applyStimulus(); checkOutput("idle.pc3", pc, 32'hC);
        expCycle = 3;
        checkCounters("idle");

        jumpTo(32'h40);
        checkOutput("jr.pc40", pc, 32'h40);
        beq = 1; rs_data = 32'd5; rt_data = 32'd5; imm16 = 16'hFFFE;
        #1 checkOutput("beq.taken", 32'(branch_taken), 32'h1);
        applyStimulus(); expCycle++; expBranch++;
        checkOutput("beq.pc", pc, 32'h3C);
        checkCounters("beq");

        jumpTo(32'h40);
        beq = 1; rs_data = 32'd5; rt_data = 32'd6; imm16 = 16'hFFFE;
        #1 checkOutput("beq.nottaken", 32'(branch_taken), 32'h0);
        applyStimulus(); expCycle++;
        checkOutput("beqn.pc", pc, 32'h44);
        checkCounters("beqn");

        jumpTo(32'h100);
        bz = 1; bz_ge = 0; rs_data = 32'hFFFF_FFFF; imm16 = 16'd3;
        applyStimulus(); expCycle++; expBranch++;
        checkOutput("bltz.pc", pc, 32'h110);
        jumpTo(32'h100);
        bz = 1; bz_ge = 1; rs_data = 32'hFFFF_FFFF; imm16 = 16'd3;
        applyStimulus(); expCycle++;
        checkOutput("bgez.pc", pc, 32'h104);
        checkCounters("bz");
        clearStrobes();

        blez = 1; rs_data = 32'h0;
        #1 checkOutput("blez.zero", 32'(branch_taken), 32'h1);
        rs_data = 32'h8000_0000;
        #1 checkOutput("blez.neg", 32'(branch_taken), 32'h1);
        rs_data = 32'h1;
        #1 checkOutput("blez.pos", 32'(branch_taken), 32'h0);
        blez = 0; bgtz = 1; rs_data = 32'h0;
        #1 checkOutput("bgtz.zero", 32'(branch_taken), 32'h0);
        rs_data = 32'h7FFF_FFFF;
        #1 checkOutput("bgtz.pos", 32'(branch_taken), 32'h1);
        bgtz = 0; bne = 1; rs_data = 32'h3; rt_data = 32'h4;
        #1 checkOutput("bne.taken", 32'(branch_taken), 32'h1);
        clearStrobes();

        jumpTo(32'h1000_0008);
        jmp = 1; target26 = 26'h000_0010;
        applyStimulus(); expCycle++; expJump++;
        checkOutput("j.pc", pc, 32'h1000_0040);
        jr = 1; jmp = 1; rs_data = 32'h0000_2003; target26 = 26'h3FF_FFFF;
        applyStimulus(); expCycle++; expJump++;
        checkOutput("jr.pc", pc, 32'h0000_2000);
        checkCounters("jump");
        clearStrobes();

        jumpTo(32'hFFFF_FFFC);
        checkOutput("wrap.plus4", pc_plus4, 32'h0);
        applyStimulus(); expCycle++;
        checkOutput("wrap.pc", pc, 32'h0);

        jumpTo(32'h200);
        syscall = 1; v0_data = 32'd10;
        applyStimulus(); expCycle++;
        checkOutput("halt.flag", 32'(halted), 32'h1);
        checkOutput("halt.pc", pc, 32'h200);
        clearStrobes();
        jmp = 1; beq = 1; rs_data = 32'd7; rt_data = 32'd7;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("halt.hold", pc, 32'h200);
        end
        checkOutput("halt.brcomb", 32'(branch_taken), 32'h1);
        checkCounters("halt");
        clearStrobes();
        go = 1;
        applyStimulus();
        checkOutput("go.pc", pc, 32'h204);
        checkOutput("go.halted", 32'(halted), 32'h0);
        checkCounters("go");
        clearStrobes();

        jumpTo(32'h200);
        syscall = 1; v0_data = 32'd1;
        applyStimulus(); expCycle++;
        checkOutput("sysnop.pc", pc, 32'h204);
        checkOutput("sysnop.halted", 32'(halted), 32'h0);
        clearStrobes();
        go = 1;
        applyStimulus(); expCycle++;
        checkOutput("goRun.pc", pc, 32'h208);
        checkCounters("run");
        clearStrobes();

        jumpTo(32'h300);
        syscall = 1; v0_data = 32'd10;
        applyStimulus();
        clearStrobes();
        applyStimulus();
        checkOutput("halt2.flag", 32'(halted), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("arst.pc", pc, 32'h0);
        checkOutput("arst.halted", 32'(halted), 32'h0);
        expCycle = 0; expJump = 0; expBranch = 0;
        checkCounters("arst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(); expCycle++;
        checkOutput("post.pc", pc, 32'h4);
        checkCounters("post");

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
